// File: rtl/mips_front_end_if.sv
// Fetch, write-back and EX/MEM bus of the MIPS front end.
interface mips_front_end_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        except;
  logic        wb_reg_write;
  logic [4:0]  wb_write_register;
  logic [31:0] wb_write_data;
  logic [31:0] res;
  logic [31:0] write_data_ex;
  logic [4:0]  write_register_ex;
  logic [2:0]  m_MEM;
  logic [1:0]  wb_MEM;
  logic        zero;
  logic        over;

  modport master (
    output imem_addr, res, write_data_ex, write_register_ex, m_MEM, wb_MEM, zero, over,
    input  imem_rdata, except, wb_reg_write, wb_write_register, wb_write_data
  );

  modport slave (
    input  imem_addr, res, write_data_ex, write_register_ex, m_MEM, wb_MEM, zero, over,
    output imem_rdata, except, wb_reg_write, wb_write_register, wb_write_data
  );
endinterface

// File: rtl/mips_front_end.sv
// MIPS front end: PC/IF-ID, decode + register file + branch resolve, execute with forwarding, EX/MEM.
// Optional MIPS_FE_OVF_EN: add/sub/addi signed overflow sets over and cancels the write-back.
module mips_front_end #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0180
) (
  input  logic             clk,
  input  logic             rst,
  mips_front_end_if.master bus
);
  localparam int unsigned XLEN = 32;
  localparam int unsigned RAW  = 5;
  localparam int unsigned NREG = 32;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_SLT = 4'd4;
  localparam logic [3:0] ALU_LUI = 4'd5;

  typedef struct packed {
    logic [1:0] wb;
    logic [2:0] m;
    logic [5:0] ex;
  } ctrl_t;

  logic [XLEN-1:0] pc, pc_next, ifid_instr, ifid_pc;
  logic [XLEN-1:0] rf [NREG];
  ctrl_t           idex_ctrl, id_ctrl;
  logic [XLEN-1:0] idex_a, idex_b, idex_imm;
  logic [RAW-1:0]  idex_rs, idex_rt, idex_rd;

  logic [5:0]      opcode, funct;
  logic [RAW-1:0]  id_rs, id_rt, id_rd;
  logic [15:0]     imm;
  logic            id_zext, id_beq, id_bne, id_j, taken, load_use;
  logic [XLEN-1:0] id_a, id_b, id_imm, pc_id4, br_off, target;

  logic [XLEN-1:0] fwd_a, fwd_b, alu_b, alu_y;
  logic [RAW-1:0]  ex_dst;
  logic            ex_ovf;

  assign bus.imem_addr = pc;
  assign opcode = ifid_instr[31:26];
  assign id_rs  = ifid_instr[25:21];
  assign id_rt  = ifid_instr[20:16];
  assign id_rd  = ifid_instr[15:11];
  assign imm    = ifid_instr[15:0];
  assign funct  = ifid_instr[5:0];

  // Decode; anything not recognised leaves all control at zero (NOP)
  always_comb begin
    id_ctrl = '0;
    id_zext = 1'b0;
    id_beq  = 1'b0;
    id_bne  = 1'b0;
    id_j    = 1'b0;
    case (opcode)
      6'h00: begin
        id_ctrl.wb    = 2'b10;
        id_ctrl.ex[5] = 1'b1;
        case (funct)
          6'h20:   id_ctrl.ex[3:0] = ALU_ADD;
          6'h22:   id_ctrl.ex[3:0] = ALU_SUB;
          6'h24:   id_ctrl.ex[3:0] = ALU_AND;
          6'h25:   id_ctrl.ex[3:0] = ALU_OR;
          6'h2a:   id_ctrl.ex[3:0] = ALU_SLT;
          default: id_ctrl = '0;
        endcase
      end
      6'h08: begin id_ctrl.wb = 2'b10; id_ctrl.ex = {2'b01, ALU_ADD}; end
      6'h0c: begin id_ctrl.wb = 2'b10; id_ctrl.ex = {2'b01, ALU_AND}; id_zext = 1'b1; end
      6'h0d: begin id_ctrl.wb = 2'b10; id_ctrl.ex = {2'b01, ALU_OR};  id_zext = 1'b1; end
      6'h0a: begin id_ctrl.wb = 2'b10; id_ctrl.ex = {2'b01, ALU_SLT}; end
      6'h0f: begin id_ctrl.wb = 2'b10; id_ctrl.ex = {2'b01, ALU_LUI}; end
      6'h23: begin id_ctrl.wb = 2'b11; id_ctrl.m = 3'b010; id_ctrl.ex = {2'b01, ALU_ADD}; end
      6'h2b: begin id_ctrl.m = 3'b001; id_ctrl.ex = {2'b01, ALU_ADD}; end
      6'h04: id_beq = 1'b1;
      6'h05: id_bne = 1'b1;
      6'h02: id_j   = 1'b1;
      default: ;
    endcase
  end

  // Register read with same-cycle write-back bypass; r0 is hard zero
  always_comb begin
    id_a = rf[id_rs];
    id_b = rf[id_rt];
    if (bus.wb_reg_write && bus.wb_write_register == id_rs) id_a = bus.wb_write_data;
    if (bus.wb_reg_write && bus.wb_write_register == id_rt) id_b = bus.wb_write_data;
    if (id_rs == '0) id_a = '0;
    if (id_rt == '0) id_b = '0;
  end

  assign id_imm   = id_zext ? {16'h0000, imm} : {{16{imm[15]}}, imm};
  assign pc_id4   = ifid_pc + 32'd4;
  assign br_off   = {{14{imm[15]}}, imm, 2'b00};
  assign target   = id_j ? {pc_id4[31:28], ifid_instr[25:0], 2'b00} : pc_id4 + br_off;
  assign taken    = id_j | (id_beq & (id_a == id_b)) | (id_bne & (id_a != id_b));
  assign load_use = idex_ctrl.m[1] && (idex_rt != '0) && (idex_rt == id_rs || idex_rt == id_rt);

  always_comb begin
    pc_next = pc + 32'd4;
    if (bus.except)    pc_next = EXC_VECTOR;
    else if (taken)    pc_next = target;
    else if (load_use) pc_next = pc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc         <= RESET_PC;
      ifid_instr <= '0;
      ifid_pc    <= '0;
    end else begin
      pc <= pc_next;
      if (bus.except || taken) begin
        ifid_instr <= '0;
        ifid_pc    <= pc;
      end else if (!load_use) begin
        ifid_instr <= bus.imem_rdata;
        ifid_pc    <= pc;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (bus.wb_reg_write && bus.wb_write_register != '0) begin
      rf[bus.wb_write_register] <= bus.wb_write_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idex_ctrl <= '0;
      idex_a    <= '0;
      idex_b    <= '0;
      idex_imm  <= '0;
      idex_rs   <= '0;
      idex_rt   <= '0;
      idex_rd   <= '0;
    end else begin
      idex_ctrl <= load_use ? ctrl_t'('0) : id_ctrl;
      idex_a    <= id_a;
      idex_b    <= id_b;
      idex_imm  <= id_imm;
      idex_rs   <= id_rs;
      idex_rt   <= id_rt;
      idex_rd   <= id_rd;
    end
  end

  // Forwarding: EX/MEM beats write-back, which beats the ID/EX copy
  always_comb begin
    fwd_a = idex_a;
    fwd_b = idex_b;
    if (bus.wb_reg_write && bus.wb_write_register != '0 && bus.wb_write_register == idex_rs) fwd_a = bus.wb_write_data;
    if (bus.wb_reg_write && bus.wb_write_register != '0 && bus.wb_write_register == idex_rt) fwd_b = bus.wb_write_data;
    if (bus.wb_MEM[1] && bus.write_register_ex != '0 && bus.write_register_ex == idex_rs) fwd_a = bus.res;
    if (bus.wb_MEM[1] && bus.write_register_ex != '0 && bus.write_register_ex == idex_rt) fwd_b = bus.res;
  end

  assign alu_b  = idex_ctrl.ex[4] ? idex_imm : fwd_b;
  assign ex_dst = idex_ctrl.ex[5] ? idex_rd : idex_rt;

  always_comb begin
    alu_y = '0;
    case (idex_ctrl.ex[3:0])
      ALU_ADD: alu_y = fwd_a + alu_b;
      ALU_SUB: alu_y = fwd_a - alu_b;
      ALU_AND: alu_y = fwd_a & alu_b;
      ALU_OR:  alu_y = fwd_a | alu_b;
      ALU_SLT: alu_y = XLEN'($signed(fwd_a) < $signed(alu_b));
      ALU_LUI: alu_y = {alu_b[15:0], 16'h0000};
      default: alu_y = '0;
    endcase
  end

`ifdef MIPS_FE_OVF_EN
  logic id_ovf_chk, idex_ovf_chk;
  assign id_ovf_chk = (opcode == 6'h00 && (funct == 6'h20 || funct == 6'h22)) || opcode == 6'h08;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) idex_ovf_chk <= 1'b0;
    else     idex_ovf_chk <= id_ovf_chk && !load_use;
  end

  always_comb begin
    ex_ovf = 1'b0;
    if (idex_ovf_chk) begin
      if (idex_ctrl.ex[3:0] == ALU_SUB)
        ex_ovf = (fwd_a[XLEN-1] != alu_b[XLEN-1]) && (alu_y[XLEN-1] != fwd_a[XLEN-1]);
      else
        ex_ovf = (fwd_a[XLEN-1] == alu_b[XLEN-1]) && (alu_y[XLEN-1] != fwd_a[XLEN-1]);
    end
  end
`else
  assign ex_ovf = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.res               <= '0;
      bus.write_data_ex     <= '0;
      bus.write_register_ex <= '0;
      bus.m_MEM             <= '0;
      bus.wb_MEM            <= '0;
      bus.zero              <= 1'b0;
      bus.over              <= 1'b0;
    end else begin
      bus.res               <= alu_y;
      bus.write_data_ex     <= fwd_b;
      bus.write_register_ex <= ex_dst;
      bus.m_MEM             <= idex_ctrl.m;
      bus.wb_MEM            <= ex_ovf ? 2'b00 : idex_ctrl.wb;
      bus.zero              <= (alu_y == '0);
      bus.over              <= ex_ovf;
    end
  end
endmodule

// File: tb/tb_mips_front_end.sv
// Directed bench for mips_front_end; the bench plays instruction memory and the MEM/WB stage.
module tb_mips_front_end;
  logic clk = 1'b0;
  logic rst;
  int   errs;
  int   checks;

  logic [31:0] imem [128];
  logic [31:0] dmem [16];

  mips_front_end_if bus ();

  mips_front_end dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  assign bus.imem_rdata = imem[bus.imem_addr[8:2]];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock; the instruction now in EX/MEM is written back during the next cycle
  task automatic tick();
    logic        we;
    logic [4:0]  wr;
    logic [31:0] wd;
    we = bus.wb_MEM[1];
    wr = bus.write_register_ex;
    wd = bus.wb_MEM[0] ? dmem[bus.res[5:2]] : bus.res;
    @(posedge clk);
    #1;
    bus.wb_reg_write      = we;
    bus.wb_write_register = wr;
    bus.wb_write_data     = wd;
  endtask

  task automatic wb_force(input logic [4:0] r, input logic [31:0] d);
    bus.wb_reg_write      = 1'b1;
    bus.wb_write_register = r;
    bus.wb_write_data     = d;
  endtask

  task automatic clear_mem();
    foreach (imem[i]) imem[i] = '0;
    foreach (dmem[i]) dmem[i] = '0;
  endtask

  // Mid-run reset must clear state at once, without waiting for a clock
  task automatic do_reset();
    rst        = 1'b1;
    bus.except = 1'b0;
    #1;
    chk("async_rst_pc", bus.imem_addr, 32'h0);
    chk("async_rst_res", bus.res, 32'h0);
    chk("async_rst_wb", 32'(bus.wb_MEM), 32'h0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_res [7];
    logic [4:0]  exp_rd  [7];
    errs   = 0;
    checks = 0;
    rst    = 1'b1;
    bus.except            = 1'b0;
    bus.wb_reg_write      = 1'b0;
    bus.wb_write_register = '0;
    bus.wb_write_data     = '0;
    clear_mem();

    // Reset state and PC stepping
    tick();
    tick();
    chk("rst_pc", bus.imem_addr, 32'h0);
    chk("rst_res", bus.res, 32'h0);
    chk("rst_wdata", bus.write_data_ex, 32'h0);
    chk("rst_wreg", 32'(bus.write_register_ex), 32'h0);
    chk("rst_m", 32'(bus.m_MEM), 32'h0);
    chk("rst_wb", 32'(bus.wb_MEM), 32'h0);
    chk("rst_zero", 32'(bus.zero), 32'h0);
    chk("rst_over", 32'(bus.over), 32'h0);
    rst = 1'b0;
    chk("pc0", bus.imem_addr, 32'h0);
    tick();
    chk("pc4", bus.imem_addr, 32'h4);
    tick();
    chk("pc8", bus.imem_addr, 32'h8);

    // ALU ops with EX/MEM, write-back and register-file bypass forwarding
    clear_mem();
    imem[0] = 32'h2001_0005;  // addi r1,r0,5
    imem[1] = 32'h2022_0003;  // addi r2,r1,3
    imem[2] = 32'h0022_1820;  // add  r3,r1,r2
    imem[3] = 32'h0001_2022;  // sub  r4,r0,r1
    imem[4] = 32'h0080_282A;  // slt  r5,r4,r0
    imem[5] = 32'h3C06_1234;  // lui  r6,0x1234
    imem[6] = 32'h3087_FFFF;  // andi r7,r4,0xFFFF
    exp_res = '{32'd5, 32'd8, 32'd13, 32'hFFFF_FFFB, 32'd1, 32'h1234_0000, 32'h0000_FFFB};
    exp_rd  = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7};
    do_reset();
    tick();
    tick();
    for (int i = 0; i < 7; i++) begin
      tick();
      chk($sformatf("alu%0d_res", i), bus.res, exp_res[i]);
      chk($sformatf("alu%0d_dst", i), 32'(bus.write_register_ex), 32'(exp_rd[i]));
    end
    chk("alu_wb", 32'(bus.wb_MEM), 32'h2);
    chk("alu_nostall_pc", bus.imem_addr, 32'd36);

    // Load-use: one hold cycle, one bubble, load value forwarded from write-back
    clear_mem();
    dmem[0] = 32'h0000_0011;
    imem[0] = 32'h8C03_0000;  // lw  r3,0(r0)
    imem[1] = 32'h0063_2020;  // add r4,r3,r3
    do_reset();
    tick();
    tick();
    chk("lu_pc_a", bus.imem_addr, 32'h8);
    tick();
    chk("lu_pc_hold", bus.imem_addr, 32'h8);
    chk("lu_lw_m", 32'(bus.m_MEM), 32'h2);
    chk("lu_lw_wb", 32'(bus.wb_MEM), 32'h3);
    chk("lu_lw_dst", 32'(bus.write_register_ex), 32'h3);
    tick();
    chk("lu_pc_b", bus.imem_addr, 32'hC);
    chk("lu_bubble_m", 32'(bus.m_MEM), 32'h0);
    chk("lu_bubble_wb", 32'(bus.wb_MEM), 32'h0);
    tick();
    chk("lu_add_res", bus.res, 32'h22);
    chk("lu_add_dst", 32'(bus.write_register_ex), 32'h4);

    // Taken beq at PC 8 flushes the fall-through instruction
    clear_mem();
    imem[2] = 32'h1022_0002;  // beq  r1,r2,+2
    imem[3] = 32'h2009_0055;  // addi r9,r0,0x55 (must be flushed)
    imem[5] = 32'h200A_0066;  // addi r10,r0,0x66
    do_reset();
    wb_force(5'd1, 32'd7);
    tick();
    wb_force(5'd2, 32'd7);
    tick();
    tick();
    chk("br_pc_pre", bus.imem_addr, 32'hC);
    tick();
    chk("br_pc_target", bus.imem_addr, 32'd20);
    tick();
    tick();
    chk("br_flush_res", bus.res, 32'h0);
    chk("br_flush_wb", 32'(bus.wb_MEM), 32'h0);
    tick();
    chk("br_tgt_res", bus.res, 32'h66);
    chk("br_tgt_dst", 32'(bus.write_register_ex), 32'd10);

    // Exception at PC 12 redirects and flushes IF/ID only
    clear_mem();
    imem[2] = 32'h2009_0055;  // addi r9,r0,0x55
    imem[3] = 32'h200B_0077;  // addi r11,r0,0x77 (must be flushed)
    do_reset();
    tick();
    tick();
    tick();
    chk("exc_pc_pre", bus.imem_addr, 32'hC);
    bus.except = 1'b1;
    tick();
    bus.except = 1'b0;
    chk("exc_pc_vec", bus.imem_addr, 32'h180);
    tick();
    chk("exc_older_res", bus.res, 32'h55);
    tick();
    chk("exc_flush_res", bus.res, 32'h0);
    chk("exc_flush_wb", 32'(bus.wb_MEM), 32'h0);

    // Signed overflow on add
    clear_mem();
    imem[0] = 32'h0021_1020;  // add r2,r1,r1
    do_reset();
    wb_force(5'd1, 32'h7FFF_FFFF);
    tick();
    tick();
    tick();
`ifdef MIPS_FE_OVF_EN
    chk("ovf_over", 32'(bus.over), 32'h1);
    chk("ovf_wb", 32'(bus.wb_MEM), 32'h0);
`else
    chk("ovf_res", bus.res, 32'hFFFF_FFFE);
    chk("ovf_over", 32'(bus.over), 32'h0);
    chk("ovf_wb", 32'(bus.wb_MEM), 32'h2);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
